// File: rtl/pc_predict.sv
// pc_predict: fetch-address select plus next-PC predictor with a circular
// return-address stack. Mispredicted jXX and ret corrections bypass the
// registered prediction combinationally; the prediction lands one cycle later.
module pc_predict #(
  parameter int             AW        = 64,
  parameter int             RAS_DEPTH = 8,
  parameter logic [AW-1:0]  RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           f_stall,
  input  logic [3:0]                     f_icode,
  input  logic [AW-1:0]                  f_valC,
  input  logic [AW-1:0]                  f_valP,
  input  logic [3:0]                     m_icode,
  input  logic                           m_cnd,
  input  logic [AW-1:0]                  m_valA,
  input  logic [3:0]                     w_icode,
  input  logic [AW-1:0]                  w_valM,
  output logic [AW-1:0]                  pc,
  output logic [AW-1:0]                  pred_pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_hit
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH+1);

  localparam logic [3:0] JXX  = 4'h7;
  localparam logic [3:0] CALL = 4'h8;
  localparam logic [3:0] RET  = 4'h9;

  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  // Occupancy counter saturates at the stack depth: a push into a full
  // stack overwrites the oldest entry instead of growing the count.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    return (cnt == DEPTH_C) ? cnt : cnt + CW'(1);
  endfunction

  // Pop never goes below zero; callers only pop when ras_hit, but keep the
  // floor here so the counter cannot wrap under any input combination.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] cnt);
    return (cnt == '0) ? cnt : cnt - CW'(1);
  endfunction

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;
  logic [PW-1:0] top_idx;
  logic          corr_m;
  logic          corr_w;
  logic          corr;
  logic          ras_upd;
  logic          push;
  logic          pop;
  logic [AW-1:0] pred_next;

  // Fetch select: memory-stage mispredict beats write-back ret, else predict.
  always_comb begin
    corr_m = (m_icode == JXX) && !m_cnd;
    corr_w = (w_icode == RET);
    corr   = corr_m || corr_w;
    pc     = pred_pc;
    if (corr_m)      pc = m_valA;
    else if (corr_w) pc = w_valM;
  end

  // Prediction and RAS control; the pointer addresses the next free slot,
  // so the top-of-stack entry sits one below it (mod depth).
  always_comb begin
    top_idx   = ras_ptr - PW'(1);
    ras_hit   = (f_icode == RET) && (ras_count != '0);
    ras_upd   = !f_stall && !corr;
    push      = ras_upd && (f_icode == CALL);
    pop       = ras_upd && ras_hit;
    pred_next = f_valP;
    if ((f_icode == JXX) || (f_icode == CALL)) pred_next = f_valC;
    else if (ras_hit)                          pred_next = ras_mem[top_idx];
  end

  // ---- stage boundary: registered prediction and RAS control state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc   <= RESET_PC;
      ras_ptr   <= '0;
      ras_count <= '0;
    end else begin
      if (!f_stall) pred_pc <= pred_next;
      if (push) begin
        ras_ptr   <= ras_ptr + PW'(1);
        ras_count <= sat_inc(ras_count);
      end else if (pop) begin
        ras_ptr   <= top_idx;
        ras_count <= sat_dec(ras_count);
      end
    end
  end

  // RAS entry storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_ptr] <= f_valP;
  end

endmodule

// File: tb/tb_pc_predict.sv
// Directed self-checking bench for pc_predict (AW=64, RAS_DEPTH=4, RESET_PC=0).
module tb_pc_predict;

  localparam int AW = 64;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_stall;
  logic [3:0]    f_icode;
  logic [AW-1:0] f_valC;
  logic [AW-1:0] f_valP;
  logic [3:0]    m_icode;
  logic          m_cnd;
  logic [AW-1:0] m_valA;
  logic [3:0]    w_icode;
  logic [AW-1:0] w_valM;
  logic [AW-1:0] pc;
  logic [AW-1:0] pred_pc;
  logic [2:0]    ras_count;
  logic          ras_hit;

  int tests  = 0;
  int failed = 0;

  pc_predict #(.AW(AW), .RAS_DEPTH(RD), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .f_stall(f_stall),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .m_icode(m_icode), .m_cnd(m_cnd), .m_valA(m_valA),
    .w_icode(w_icode), .w_valM(w_valM),
    .pc(pc), .pred_pc(pred_pc), .ras_count(ras_count), .ras_hit(ras_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; f_stall = 1'b0;
    f_icode = 4'h1; f_valC = '0; f_valP = '0;
    m_icode = 4'h0; m_cnd = 1'b0; m_valA = '0;
    w_icode = 4'h0; w_valM = '0;

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("rst_pred_pc", pred_pc, 64'h0);
    check("rst_pc", pc, 64'h0);
    check("rst_count", {61'd0, ras_count}, 64'd0);
    check("rst_hit", {63'd0, ras_hit}, 64'd0);
    step();
    rst_n = 1'b1;

    // Branch prediction, then memory-stage mispredict correction
    f_icode = 4'h7; f_valC = 64'd56; f_valP = 64'd32;
    step();
    check("br_pred", pred_pc, 64'd56);
    check("br_pc", pc, 64'd56);
    f_icode = 4'h8; f_valC = 64'h123; f_valP = 64'h11;
    m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'd32;
    #1;
    check("br_corr_pc", pc, 64'd32);
    step();
    check("br_corr_count", {61'd0, ras_count}, 64'd0);
    check("br_corr_pred", pred_pc, 64'h123);
    m_icode = 4'h0;

    // Call then ret
    f_icode = 4'h8; f_valC = 64'h100; f_valP = 64'h20;
    step();
    check("call_pred", pred_pc, 64'h100);
    check("call_count", {61'd0, ras_count}, 64'd1);
    f_icode = 4'h9; f_valP = 64'hAA;
    #1;
    check("ret_hit", {63'd0, ras_hit}, 64'd1);
    step();
    check("ret_pred", pred_pc, 64'h20);
    check("ret_count", {61'd0, ras_count}, 64'd0);

    // Overflow: five calls into a four-entry stack
    for (int i = 1; i <= 5; i++) begin
      f_icode = 4'h8; f_valC = 64'h200; f_valP = 64'(i * 16);
      step();
      check($sformatf("ovf_count%0d", i), {61'd0, ras_count}, 64'((i < RD) ? i : RD));
    end
    // Four rets recover the newest four return addresses
    f_icode = 4'h9; f_valP = 64'hAA;
    step(); check("pop1", pred_pc, 64'h50);
    step(); check("pop2", pred_pc, 64'h40);
    step(); check("pop3", pred_pc, 64'h30);
    step(); check("pop4", pred_pc, 64'h20);
    check("pop_count", {61'd0, ras_count}, 64'd0);
    // Underflow ret falls back to fall-through
    f_valP = 64'h99;
    #1;
    check("unf_hit", {63'd0, ras_hit}, 64'd0);
    step();
    check("unf_pred", pred_pc, 64'h99);
    check("unf_count", {61'd0, ras_count}, 64'd0);

    // Stall holds both prediction and RAS
    f_icode = 4'h8; f_valC = 64'h700; f_valP = 64'h60;
    step();
    check("pre_stall_pred", pred_pc, 64'h700);
    f_stall = 1'b1; f_valC = 64'h300; f_valP = 64'h61;
    step();
    check("stall_pred", pred_pc, 64'h700);
    check("stall_count", {61'd0, ras_count}, 64'd1);
    f_stall = 1'b0;

    // Priority: mispredict over ret, then ret alone; RAS untouched
    f_icode = 4'h9; f_valP = 64'h500;
    m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h40;
    w_icode = 4'h9; w_valM = 64'h80;
    #1;
    check("prio_m", pc, 64'h40);
    step();
    check("prio_m_count", {61'd0, ras_count}, 64'd1);
    check("prio_m_pred", pred_pc, 64'h60);
    m_icode = 4'h0;
    #1;
    check("prio_w", pc, 64'h80);
    step();
    check("prio_w_count", {61'd0, ras_count}, 64'd1);
    // Taken branch in memory stage is no correction: ret pops
    w_icode = 4'h0; m_icode = 4'h7; m_cnd = 1'b1;
    #1;
    check("taken_pc", pc, 64'h60);
    step();
    check("taken_count", {61'd0, ras_count}, 64'd0);
    m_icode = 4'h0; m_cnd = 1'b0;

    // Mid-operation reset with a write-back ret still steering pc
    f_icode = 4'h8; f_valC = 64'h900; f_valP = 64'h33;
    step();
    check("pre_rst_count", {61'd0, ras_count}, 64'd1);
    #2 rst_n = 1'b0; w_icode = 4'h9; w_valM = 64'h80;
    #1;
    check("mid_rst_pred", pred_pc, 64'h0);
    check("mid_rst_count", {61'd0, ras_count}, 64'd0);
    check("mid_rst_pc", pc, 64'h80);
    step();
    rst_n = 1'b1; w_icode = 4'h0;
    f_icode = 4'h9; f_valP = 64'h77;
    #1;
    check("post_rst_hit", {63'd0, ras_hit}, 64'd0);
    step();
    check("post_rst_pred", pred_pc, 64'h77);
    check("post_rst_pc", pc, 64'h77);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_predict.md
PC_PREDICT -- requirements
Module: pc_predict

Interface
REQ-001 Parameter AW, default 64: address/data width of all PC-related buses.
REQ-002 Parameter RAS_DEPTH, default 8: return-address-stack entries (power of two, >=2).
REQ-003 Parameter RESET_PC, default 0: value loaded into pred_pc on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 f_stall  input  1  hold fetch state this cycle.
REQ-007 f_icode  input  4  icode of the instruction fetched at pc.
REQ-008 f_valC  input  AW  constant word of the fetched instruction.
REQ-009 f_valP  input  AW  fall-through address of the fetched instruction.
REQ-010 m_icode  input  4  icode in the memory stage.
REQ-011 m_cnd  input  1  branch condition resolved for the memory-stage instruction.
REQ-012 m_valA  input  AW  fall-through address carried by the memory-stage jXX.
REQ-013 w_icode  input  4  icode in the write-back stage.
REQ-014 w_valM  input  AW  return address read by the write-back-stage ret.
REQ-015 pc  output  AW  selected fetch address (combinational).
REQ-016 pred_pc  output  AW  registered predicted next PC.
REQ-017 ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries.
REQ-018 ras_hit  output  1  combinational; high when f_icode==RET and ras_count>0.

Function
REQ-019 Encodings: JXX=4'h7, CALL=4'h8, RET=4'h9.
REQ-020 Select priority: (m_icode==JXX && !m_cnd) -> pc=m_valA; else w_icode==RET -> pc=w_valM; else pc=pred_pc.
REQ-021 "Correction cycle" = either of the first two select cases active.
REQ-022 Prediction: f_icode JXX or CALL -> f_valC; RET with ras_hit -> RAS top entry; RET with empty RAS -> f_valP; all other icodes -> f_valP.
REQ-023 pred_pc loads the prediction on each rising edge with f_stall==0; with f_stall==1 it holds, including during a correction cycle.
REQ-024 RAS updates only on edges with f_stall==0 and no correction cycle; otherwise contents and ras_count hold.
REQ-025 CALL push: write f_valP at top pointer, pointer+1 modulo RAS_DEPTH, ras_count+1 saturating at RAS_DEPTH.
REQ-026 Full push: overwrites oldest entry (circular wrap); ras_count stays RAS_DEPTH.
REQ-027 RET with ras_count>0 pops: pointer-1 modulo RAS_DEPTH, ras_count-1.
REQ-028 RET on empty RAS: no pointer/count change, no underflow.
REQ-029 Only one of push/pop per cycle (single f_icode); no other icode touches RAS.
REQ-030 Latency: prediction visible on pred_pc one cycle after the fetch; corrections reach pc in zero cycles.
REQ-031 Pipeline squash/bubble control is external; this block only selects and predicts.

Reset
REQ-032 rst_n low asynchronously forces pred_pc=RESET_PC, ras_count=0, RAS pointer=0; entry contents don't-care.
REQ-033 Reset asserted mid-operation discards all pending predictions and RAS state immediately; first edge after release behaves per REQ-023..028.
REQ-034 While rst_n low, pc follows REQ-020 combinationally with pred_pc=RESET_PC.

Verification (AW=64, RAS_DEPTH=4, RESET_PC=0)
REQ-035 Reset: rst_n=0 mid-cycle, idle m/w -> pred_pc=0, pc=0, ras_count=0 without waiting for clk.
REQ-036 Branch: f_icode=7, f_valC=56, f_valP=32 -> pred_pc=56 next edge; then m_icode=7, m_cnd=0, m_valA=32 -> pc=32 same cycle, RAS unchanged.
REQ-037 Call/ret: f_icode=8, f_valC=0x100, f_valP=0x20 -> pred_pc=0x100, ras_count=1; then f_icode=9 -> ras_hit=1, pred_pc=0x20, ras_count=0.
REQ-038 Overflow/underflow: 5 CALLs, f_valP=0x10..0x50 -> ras_count=4; 4 RETs predict 0x50,0x40,0x30,0x20; 5th RET (f_valP=0x99) -> ras_hit=0, pred_pc=0x99, ras_count=0.
REQ-039 Stall: f_stall=1, f_icode=8, f_valC=0x300 -> pred_pc and ras_count unchanged across edge.
REQ-040 Priority: m_icode=7, m_cnd=0, m_valA=0x40 with w_icode=9, w_valM=0x80 -> pc=0x40; drop m mispredict -> pc=0x80; RAS untouched both cycles.
